// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in / parallel-out receiver.
// Parity framing is selected at build time with SIPO_PARITY_EN.
package sipo_pkg;

  localparam int DEF_WIDTH = 4;

  // Expected XOR over data plus parity bit for a clean even-parity frame.
  localparam logic PARITY_EVEN = 1'b0;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic parity_bad(input logic xor_all);
    return (xor_all != PARITY_EVEN);
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// Single-entry valid/ready holding register; reports a completed word it had to drop.
// Carries the parity flag alongside the data so both update together.
module sipo_hold_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         perr_in,
  input  logic         pready,
  output logic [W-1:0] pdata,
  output logic         pvalid,
  output logic         perr,
  output logic         drop
);

  logic accept_s;

  // A new word is taken when the slot is empty or is being drained on this edge.
  always_comb begin
    accept_s = 1'b0;
    drop     = 1'b0;
    if (load) begin
      accept_s = (!pvalid) || pready;
      drop     = pvalid && !pready;
    end else begin
      accept_s = 1'b0;
      drop     = 1'b0;
    end
  end

  // Data and parity flag keep their last value after consumption.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pdata  <= {W{1'b0}};
      perr   <= 1'b0;
      pvalid <= 1'b0;
    end else if (accept_s) begin
      pdata  <= data_in;
      perr   <= perr_in;
      pvalid <= 1'b1;
    end else if (pvalid && pready) begin
      pvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// MSB-first serial receiver presenting words on a valid/ready port.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per word.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sdi,
  input  logic             sdi_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] pdata,
  output logic             pvalid,
  input  logic             pready,
  output logic             ovf,
  input  logic             clr_ovf,
  output logic             parity_err
);

  localparam int CNT_W = cnt_width(WIDTH);

`ifdef SIPO_PARITY_EN
  localparam int SH_W = WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
  localparam int SH_W = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

  logic [SH_W-1:0]  shreg_r;
  logic [SH_W-1:0]  shreg_next_s;
  logic [SH_W:0]    shift_in_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_base_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [WIDTH-1:0] word_s;
  logic             complete_s;
  logic             perr_s;
  logic             drop_s;
  logic             ovf_r;

  // sync restarts the count before this cycle's bit is considered.
  always_comb begin
    cnt_base_s   = sync ? {CNT_W{1'b0}} : cnt_r;
    shift_in_s   = {shreg_r, sdi};
    shreg_next_s = shreg_r;
    cnt_next_s   = cnt_base_s;
    complete_s   = 1'b0;
    if (sdi_valid) begin
      shreg_next_s = shift_in_s[SH_W-1:0];
      if (cnt_base_s == LAST_CNT) begin
        complete_s = 1'b1;
        cnt_next_s = {CNT_W{1'b0}};
      end else begin
        cnt_next_s = cnt_base_s + CNT_W'(1);
      end
    end else begin
      shreg_next_s = shreg_r;
      cnt_next_s   = cnt_base_s;
    end
  end

  // In parity mode the register already holds the data when the parity bit arrives.
  always_comb begin
`ifdef SIPO_PARITY_EN
    word_s = shreg_r;
    perr_s = parity_bad(^shift_in_s);
`else
    word_s = shift_in_s;
    perr_s = 1'b0;
`endif
  end

  // Shift register and bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_r <= {SH_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      shreg_r <= shreg_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Sticky overflow; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_r <= 1'b0;
    end
  end

  sipo_hold_reg #(
    .W (WIDTH)
  ) u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (complete_s),
    .data_in (word_s),
    .perr_in (perr_s),
    .pready  (pready),
    .pdata   (pdata),
    .pvalid  (pvalid),
    .perr    (parity_err),
    .drop    (drop_s)
  );

  assign ovf = ovf_r;

endmodule
